digicode_multi: RTL
===================

Name: digicode_multi

Overview:
Parametrised keypad access controller; next generation of the single-code digicode FSM.
- Accepts a CODE_LEN-digit code with per-key strobes and a compare-at-end check, so it does not reveal which digit was wrong.
- Times the door-open and alarm pulses, and counts consecutive failures to enter a timed lockout.
- Sits between the keypad scanner (key_valid/code) and the door-strike/alarm drivers.

Parameters:
- CODE_LEN, 5, number of digits in the access code (2..8).
- DEFAULT_CODE, 20'h28B04, reset code; CODE_LEN*4 bits; first digit in the MS nibble.
- DOOR_HOLD, 16, cycles door stays asserted in OPEN.
- ALARM_HOLD, 8, cycles alarm stays asserted in WRONG.
- MAX_TRIES, 3, consecutive failures that trigger LOCKOUT.
- LOCK_CYCLES, 64, LOCKOUT duration in cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; code is sampled only when this is 1.
- code  in  4  key value: 0-11 are digits (A=10, B=11), 12=C (clear), 13=P (passkey), 14/15 ignored.
- timeout  in  1  inter-key timeout pulse from an external timer.
- daytime  in  1  enables passkey P.
- door  out  1  door strike; high only in OPEN.
- alarm  out  1  high in WRONG and LOCKOUT.
- locked  out  1  high only in LOCKOUT.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failure count.

Behaviour:
- States: IDLE, ENTRY, OPEN, WRONG, LOCKOUT. One-hot state register; outputs are a Moore decode of the state.
- Latency: the response is visible one clock after the key is sampled.
- Reset: state=IDLE, idx=0, mismatch=0, timer=0, fail_cnt=0, door=0, alarm=0, locked=0, stored code=DEFAULT_CODE. Reset mid-operation aborts any state within one edge.
- Priority in IDLE/ENTRY on the same cycle: timeout (ENTRY only) > C > P > digit.
- IDLE:
  - digit key: compare against digit 0, set mismatch, idx=1, go to ENTRY.
  - C: stay in IDLE.
  - P with daytime=1: go to OPEN. P with daytime=0: go to WRONG.
  - timeout, 14/15, or no key: stay in IDLE.
- ENTRY:
  - Each digit compares against digit[idx] and ORs the result into a sticky mismatch; idx increments.
  - On digit CODE_LEN-1: go to OPEN if the final mismatch is 0, else go to WRONG.
  - C: go to IDLE, clear idx and mismatch; fail_cnt unchanged.
  - P: same as in IDLE.
  - timeout=1: go to WRONG; any simultaneous key is discarded.
- OPEN:
  - On entry, clear fail_cnt and load timer=DOOR_HOLD-1; door=1.
  - Return to IDLE when the timer reaches 0, giving exactly DOOR_HOLD cycles of door.
  - C closes early: go to IDLE next edge. All other keys are ignored.
- WRONG:
  - On entry, saturating-increment fail_cnt; alarm=1 for ALARM_HOLD cycles.
  - Then go to LOCKOUT if fail_cnt==MAX_TRIES, else go to IDLE.
  - All keys are ignored, including C.
- LOCKOUT:
  - alarm=1, locked=1 for LOCK_CYCLES cycles; all keys and timeout are ignored.
  - On exit, clear fail_cnt and go to IDLE.
- idx, mismatch and the timer are cleared on every return to IDLE.
- The timer is a single down-counter, width $clog2 of the largest hold parameter, shared by OPEN, WRONG and LOCKOUT. It never wraps.
- Unreachable state encodings go to IDLE on the next edge.

Optional Feature:
- Macro: DIGICODE_PROG_EN.
- When defined, add ports:
  - prog_we  in  1  code-write strobe.
  - prog_code  in  CODE_LEN*4  new code value.
- prog_we=1 loads prog_code into the stored code register, but only when state==IDLE; it is ignored in all other states.
- The new code takes effect for the next entry.
- When not defined: no extra ports; the stored code is the constant DEFAULT_CODE.

Test Plan:
- Keys 2,8,B,0,4 (each key_valid pulse, daytime=0) -> door=1 exactly 16 cycles starting one cycle after the key "4"; alarm=0; fail_cnt=0.
- Keys 2,8,B,0,5 -> no door; alarm=1 for 8 cycles after "5"; fail_cnt=1; back to IDLE.
- Three wrong 5-digit entries -> after the third WRONG: locked=1, alarm=1 for 64 cycles; key 2,8,B,0,4 during LOCKOUT is ignored; afterwards fail_cnt=0 and the correct code opens the door.
- Keys 2,8 then timeout=1 together with key B -> WRONG (alarm); key B discarded; fail_cnt increments.
- Key P with daytime=1 in IDLE -> OPEN; key C in OPEN -> door=0 next cycle. Key P with daytime=0 -> WRONG.
- With DIGICODE_PROG_EN: prog_we with 20'h13579 in IDLE -> 1,3,5,7,9 opens the door and 2,8,B,0,4 raises the alarm. prog_we asserted during OPEN -> code unchanged.

Source files
------------

// File: rtl/digicode_multi.sv
// Multi-digit keypad access controller with door/alarm timing and lockout.
// Define DIGICODE_PROG_EN to make the access code writable while idle.
module digicode_multi #(
    parameter int                    CODE_LEN     = 5,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 20'h28B04,
    parameter int                    DOOR_HOLD    = 16,
    parameter int                    ALARM_HOLD   = 8,
    parameter int                    MAX_TRIES    = 3,
    parameter int                    LOCK_CYCLES  = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_valid,
    input  logic [3:0]                         code,
    input  logic                               timeout,
    input  logic                               daytime,
    output logic                               door,
    output logic                               alarm,
    output logic                               locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
`ifdef DIGICODE_PROG_EN
    ,
    input  logic                               prog_we,
    input  logic [CODE_LEN*4-1:0]              prog_code
`endif
);

    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int IDXW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int HM1  = (DOOR_HOLD > ALARM_HOLD) ? DOOR_HOLD : ALARM_HOLD;
    localparam int HMAX = (HM1 > LOCK_CYCLES) ? HM1 : LOCK_CYCLES;
    localparam int TW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        ENTRY   = 5'b00010,
        OPEN    = 5'b00100,
        WRONG   = 5'b01000,
        LOCKOUT = 5'b10000
    } state_t;

    state_t                state, state_n;
    logic [IDXW-1:0]       idx, idx_n;
    logic                  mismatch, mis_n;
    logic [TW-1:0]         timer, timer_n;
    logic [FW-1:0]         fail_n;
    logic [CODE_LEN*4-1:0] code_q;
    logic [3:0]            cur_digit;
    logic                  is_digit, is_c, is_p, dig_ne;

`ifdef DIGICODE_PROG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= DEFAULT_CODE;
        end else if (prog_we && state == IDLE) begin
            code_q <= prog_code;
        end
    end
`else
    assign code_q = DEFAULT_CODE;
`endif

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == IDXW'(i)) begin
                cur_digit = code_q[(CODE_LEN-1-i)*4 +: 4];
            end
        end
    end

    assign is_digit = key_valid && (code <= 4'd11);
    assign is_c     = key_valid && (code == 4'd12);
    assign is_p     = key_valid && (code == 4'd13);
    assign dig_ne   = (code != cur_digit);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        mis_n   = mismatch;
        timer_n = timer;
        fail_n  = fail_cnt;
        case (state)
            IDLE: begin
                if (is_c) begin
                    state_n = IDLE;
                end else if (is_p) begin
                    state_n = daytime ? OPEN : WRONG;
                end else if (is_digit) begin
                    mis_n   = dig_ne;
                    idx_n   = IDXW'(1);
                    state_n = ENTRY;
                end
            end
            ENTRY: begin
                if (timeout) begin
                    state_n = WRONG;
                end else if (is_c) begin
                    state_n = IDLE;
                end else if (is_p) begin
                    state_n = daytime ? OPEN : WRONG;
                end else if (is_digit) begin
                    mis_n = mismatch | dig_ne;
                    if (idx == IDXW'(CODE_LEN - 1)) begin
                        state_n = mis_n ? WRONG : OPEN;
                    end else begin
                        idx_n = idx + IDXW'(1);
                    end
                end
            end
            OPEN: begin
                if (is_c || timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            WRONG: begin
                if (timer == '0) begin
                    state_n = (fail_cnt == FW'(MAX_TRIES)) ? LOCKOUT : IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Entry actions are applied on the edge that changes state
        if (state_n != state) begin
            case (state_n)
                OPEN: begin
                    timer_n = TW'(DOOR_HOLD - 1);
                    fail_n  = '0;
                end
                WRONG: begin
                    timer_n = TW'(ALARM_HOLD - 1);
                    if (fail_cnt != FW'(MAX_TRIES)) begin
                        fail_n = fail_cnt + FW'(1);
                    end
                end
                LOCKOUT: begin
                    timer_n = TW'(LOCK_CYCLES - 1);
                end
                IDLE: begin
                    idx_n   = '0;
                    mis_n   = 1'b0;
                    timer_n = '0;
                end
                default: begin
                    timer_n = timer_n;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            mismatch <= 1'b0;
            timer    <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            mismatch <= mis_n;
            timer    <= timer_n;
            fail_cnt <= fail_n;
        end
    end

    assign door   = (state == OPEN);
    assign alarm  = (state == WRONG) || (state == LOCKOUT);
    assign locked = (state == LOCKOUT);

endmodule
